sram_port_arbiter: RTL and testbench

//  Shares one SRAM-like memory port between the IF fetch requester (inst) and the MEM load/store requester (data).

---
 rtl/sram_port_arbiter_pkg.sv | 11 +
 rtl/arb_id_fifo.sv | 59 +++++
 rtl/sram_port_arbiter.sv | 136 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// rtl/sram_port_arbiter_pkg.sv - requester IDs and transfer size encodings shared by the arbiter
package sram_port_arbiter_pkg;

    localparam logic REQ_INST = 1'b0;
    localparam logic REQ_DATA = 1'b1;

    localparam logic [1:0] SIZE_1B = 2'd0;
    localparam logic [1:0] SIZE_2B = 2'd1;
    localparam logic [1:0] SIZE_4B = 2'd2;

endpackage

// File: rtl/arb_id_fifo.sv
// rtl/arb_id_fifo.sv - in-order queue of 1-bit requester IDs for outstanding transactions
module arb_id_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic push_id_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] slot_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = slot_q[rd_ptr_q];

    // Full/empty come from the registered count, so a pop never frees a slot for a push in the same cycle.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                slot_q[wr_ptr_q] <= push_id_i;
                wr_ptr_q         <= next_ptr(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one SRAM-like port between inst and data requesters
// SRAM_ARB_RR_EN selects round-robin grant; SRAM_ARB_POP_CHECK enables the empty-pop simulation assertion.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [3:0]        inst_wstrb,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [3:0]        data_wstrb,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic lock_valid_q, lock_valid_d;
    logic lock_id_q, lock_id_d;
    logic grant;
    logic grant_req;
    logic q_full, q_empty, q_head;
    logic push, pop_valid;

`ifdef SRAM_ARB_RR_EN
    logic rr_q;

    always_comb begin
        if (lock_valid_q)
            grant = lock_id_q;
        else if (inst_req && data_req)
            grant = rr_q;
        else
            grant = data_req ? REQ_DATA : REQ_INST;
    end

    // rr_q names the requester preferred on the next contended, unlocked cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_q <= REQ_INST;
        else if (push)
            rr_q <= ~grant;
    end
`else
    always_comb begin
        if (lock_valid_q)
            grant = lock_id_q;
        else
            grant = data_req ? REQ_DATA : REQ_INST;
    end
`endif

    assign grant_req = (grant == REQ_DATA) ? data_req : inst_req;

    // Gated by rst so the port goes quiet asynchronously, before state even settles.
    assign mem_req   = ~rst & grant_req & ~q_full;
    assign mem_wr    = (grant == REQ_DATA) ? data_wr    : inst_wr;
    assign mem_size  = (grant == REQ_DATA) ? data_size  : inst_size;
    assign mem_addr  = (grant == REQ_DATA) ? data_addr  : inst_addr;
    assign mem_wstrb = (grant == REQ_DATA) ? data_wstrb : inst_wstrb;
    assign mem_wdata = (grant == REQ_DATA) ? data_wdata : inst_wdata;

    assign push         = mem_req & mem_addr_ok;
    assign inst_addr_ok = push & (grant == REQ_INST);
    assign data_addr_ok = push & (grant == REQ_DATA);

    assign pop_valid    = ~rst & mem_data_ok & ~q_empty;
    assign inst_data_ok = pop_valid & (q_head == REQ_INST);
    assign data_data_ok = pop_valid & (q_head == REQ_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_comb begin
        lock_valid_d = lock_valid_q;
        lock_id_d    = lock_id_q;
        if (mem_req && !mem_addr_ok) begin
            lock_valid_d = 1'b1;
            lock_id_d    = grant;
        end else if (push) begin
            lock_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_valid_q <= 1'b0;
            lock_id_q    <= REQ_INST;
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
        end
    end

    arb_id_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .push_id_i (grant),
        .pop_i     (pop_valid),
        .full_o    (q_full),
        .empty_o   (q_empty),
        .head_o    (q_head)
    );

`ifdef SRAM_ARB_POP_CHECK
    always_ff @(posedge clk) begin
        if (!rst) assert (!(mem_data_ok && q_empty));
    end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed scenarios plus randomized traffic against a transaction-level model
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;

    localparam int OUTS = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
`ifdef SRAM_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic          clk, rst;
    logic          inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]    inst_size;
    logic [AW-1:0] inst_addr;
    logic [3:0]    inst_wstrb;
    logic [DW-1:0] inst_wdata, inst_rdata;
    logic          data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]    data_size;
    logic [AW-1:0] data_addr;
    logic [3:0]    data_wstrb;
    logic [DW-1:0] data_wdata, data_rdata;
    logic          mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wstrb;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    sram_port_arbiter #(.OUTSTANDING(OUTS), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = SIZE_4B; inst_addr = '0; inst_wstrb = 4'hF; inst_wdata = '0;
        data_req = 0; data_wr = 0; data_size = SIZE_4B; data_addr = '0; data_wstrb = 4'hF; data_wdata = '0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        step();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
        step();
    endtask

    task automatic test_reset();
        rst = 1;
        inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %0b exp 0", mem_req); end
        checks++; if (inst_addr_ok !== 1'b0) begin errors++; $display("FAIL reset_inst_addr_ok got %0b exp 0", inst_addr_ok); end
        checks++; if (data_addr_ok !== 1'b0) begin errors++; $display("FAIL reset_data_addr_ok got %0b exp 0", data_addr_ok); end
        checks++; if (inst_data_ok !== 1'b0) begin errors++; $display("FAIL reset_inst_data_ok got %0b exp 0", inst_data_ok); end
        checks++; if (data_data_ok !== 1'b0) begin errors++; $display("FAIL reset_data_data_ok got %0b exp 0", data_data_ok); end
        step();
        idle_inputs();
        step();
        rst = 0;
    endtask

    task automatic test_inst_read();
        logic [DW-1:0] rd;
        rd = $urandom;
        step();
        inst_req = 1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1;
        #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL inst_read_mem_req got %0b exp 1", mem_req); end
        checks++; if (mem_addr !== 32'h1C00_0000) begin errors++; $display("FAIL inst_read_mem_addr got %h exp 1c000000", mem_addr); end
        checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL inst_read_addr_ok got %0b exp 1", inst_addr_ok); end
        checks++; if (data_addr_ok !== 1'b0) begin errors++; $display("FAIL inst_read_data_addr_ok got %0b exp 0", data_addr_ok); end
        step();
        inst_req = 0; mem_addr_ok = 0;
        step();
        mem_data_ok = 1; mem_rdata = rd;
        #1;
        checks++; if (inst_data_ok !== 1'b1) begin errors++; $display("FAIL inst_read_data_ok got %0b exp 1", inst_data_ok); end
        checks++; if (data_data_ok !== 1'b0) begin errors++; $display("FAIL inst_read_data_data_ok got %0b exp 0", data_data_ok); end
        checks++; if (inst_rdata !== rd) begin errors++; $display("FAIL inst_read_rdata got %h exp %h", inst_rdata, rd); end
        step();
        mem_data_ok = 0;
    endtask

    task automatic test_both();
        step();
        inst_req = 1; inst_addr = 32'h1C00_0100;
        data_req = 1; data_addr = 32'h8000_0200;
        mem_addr_ok = 1;
        #1;
        checks++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin errors++; $display("FAIL both_first_grant got inst=%0b data=%0b exp inst=0 data=1", inst_addr_ok, data_addr_ok); end
        checks++; if (mem_addr !== 32'h8000_0200) begin errors++; $display("FAIL both_first_addr got %h exp 80000200", mem_addr); end
        step();
        data_req = 0;
        #1;
        checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL both_second_grant got %0b exp 1", inst_addr_ok); end
        checks++; if (mem_addr !== 32'h1C00_0100) begin errors++; $display("FAIL both_second_addr got %h exp 1c000100", mem_addr); end
        step();
        inst_req = 0; mem_addr_ok = 0;
        step();
        mem_data_ok = 1;
        #1;
        checks++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin errors++; $display("FAIL both_resp1 got inst=%0b data=%0b exp inst=0 data=1", inst_data_ok, data_data_ok); end
        step();
        checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin errors++; $display("FAIL both_resp2 got inst=%0b data=%0b exp inst=1 data=0", inst_data_ok, data_data_ok); end
        step();
        mem_data_ok = 0;
    endtask

    task automatic test_lock();
        step();
        inst_req = 1; inst_wr = 1; inst_addr = 32'h1C00_0040; inst_wdata = 32'hA5A5_0001;
        mem_addr_ok = 0;
        #1;
        checks++; if (mem_req !== 1'b1 || inst_addr_ok !== 1'b0) begin errors++; $display("FAIL lock_start got req=%0b aok=%0b exp req=1 aok=0", mem_req, inst_addr_ok); end
        for (int i = 0; i < 2; i++) begin
            step();
            data_req = 1; data_addr = 32'h8000_0040; data_wdata = 32'h5A5A_0002;
            #1;
            checks++; if (mem_addr !== 32'h1C00_0040 || mem_wdata !== 32'hA5A5_0001 || mem_wr !== 1'b1) begin errors++; $display("FAIL lock_hold%0d got addr=%h wdata=%h wr=%0b exp addr=1c000040 wdata=a5a50001 wr=1", i, mem_addr, mem_wdata, mem_wr); end
        end
        mem_addr_ok = 1;
        #1;
        checks++; if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin errors++; $display("FAIL lock_release got inst=%0b data=%0b exp inst=1 data=0", inst_addr_ok, data_addr_ok); end
        step();
        inst_req = 0; inst_wr = 0;
        #1;
        checks++; if (data_addr_ok !== 1'b1 || mem_addr !== 32'h8000_0040) begin errors++; $display("FAIL lock_next got aok=%0b addr=%h exp aok=1 addr=80000040", data_addr_ok, mem_addr); end
        step();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        #1;
        checks++; if (inst_data_ok !== 1'b1) begin errors++; $display("FAIL lock_resp1 got %0b exp 1", inst_data_ok); end
        step();
        checks++; if (data_data_ok !== 1'b1) begin errors++; $display("FAIL lock_resp2 got %0b exp 1", data_data_ok); end
        step();
        mem_data_ok = 0;
    endtask

    task automatic test_full();
        step();
        inst_req = 1; inst_addr = 32'h1C00_1000; mem_addr_ok = 1;
        #1;
        checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL full_acc1 got %0b exp 1", inst_addr_ok); end
        step();
        inst_addr = 32'h1C00_1004;
        #1;
        checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL full_acc2 got %0b exp 1", inst_addr_ok); end
        step();
        inst_addr = 32'h1C00_1008;
        #1;
        checks++; if (mem_req !== 1'b0 || inst_addr_ok !== 1'b0) begin errors++; $display("FAIL full_block got req=%0b aok=%0b exp 0 0", mem_req, inst_addr_ok); end
        step();
        mem_data_ok = 1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL full_block_on_pop got %0b exp 0", mem_req); end
        checks++; if (inst_data_ok !== 1'b1) begin errors++; $display("FAIL full_pop got %0b exp 1", inst_data_ok); end
        step();
        mem_data_ok = 0;
        #1;
        checks++; if (mem_req !== 1'b1 || inst_addr_ok !== 1'b1) begin errors++; $display("FAIL full_unblock got req=%0b aok=%0b exp 1 1", mem_req, inst_addr_ok); end
        step();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        step();
        step();
        mem_data_ok = 0;
    endtask

    task automatic test_reset_mid();
        step();
        inst_req = 1; mem_addr_ok = 1;
        step();
        step();
        rst = 1; data_req = 1; mem_data_ok = 1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_mem_req got %0b exp 0", mem_req); end
        checks++; if (inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin errors++; $display("FAIL rstmid_addr_ok got inst=%0b data=%0b exp 0 0", inst_addr_ok, data_addr_ok); end
        checks++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin errors++; $display("FAIL rstmid_data_ok got inst=%0b data=%0b exp 0 0", inst_data_ok, data_data_ok); end
        step();
        idle_inputs();
        rst = 0;
        step();
        mem_data_ok = 1;
        #1;
        checks++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin errors++; $display("FAIL spurious_data_ok got inst=%0b data=%0b exp 0 0", inst_data_ok, data_data_ok); end
        step();
        mem_data_ok = 0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL post_reset_idle got %0b exp 0", mem_req); end
    endtask

`ifdef SRAM_ARB_RR_EN
    task automatic test_rr();
        do_reset();
        inst_req = 1; data_req = 1; mem_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            mem_data_ok = (i > 0);
            #1;
            checks++;
            if (inst_addr_ok !== (i % 2 == 0) || data_addr_ok !== (i % 2 == 1)) begin
                errors++; $display("FAIL rr_grant%0d got inst=%0b data=%0b exp inst=%0b", i, inst_addr_ok, data_addr_ok, (i % 2 == 0));
            end
            step();
        end
        inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        step();
        mem_data_ok = 0;
    endtask
`endif

    // Model: grant rules and an in-order list of issuing requesters; never consults DUT state.
    task automatic test_random();
        bit   q[$];
        bit   lock_v, lock_id, rr_pref, clr_inst, clr_data;
        logic g, greq, exp_req, acc, exp_dok, head;
        lock_v = 0; lock_id = 0; rr_pref = REQ_INST; clr_inst = 0; clr_data = 0;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (clr_inst) inst_req = 0;
            if (clr_data) data_req = 0;
            if (!inst_req && $urandom_range(0, 2) == 0) begin
                inst_req = 1; inst_addr = $urandom; inst_wdata = $urandom; inst_wr = 1'($urandom_range(0, 1));
            end
            if (!data_req && $urandom_range(0, 2) == 0) begin
                data_req = 1; data_addr = $urandom; data_wdata = $urandom; data_wr = 1'($urandom_range(0, 1));
            end
            mem_addr_ok = 1'($urandom_range(0, 1));
            mem_data_ok = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            mem_rdata   = $urandom;

            if (lock_v) g = lock_id;
            else if (inst_req && data_req) g = RR_MODE ? rr_pref : REQ_DATA;
            else g = data_req;
            greq    = g ? data_req : inst_req;
            exp_req = greq && (q.size() < OUTS);
            acc     = exp_req && mem_addr_ok;
            exp_dok = mem_data_ok && (q.size() > 0);
            head    = (q.size() > 0) ? q[0] : 1'b0;
            #1;
            checks++; if (mem_req !== exp_req) begin errors++; $display("FAIL rand_mem_req cyc %0d got %0b exp %0b", cyc, mem_req, exp_req); end
            checks++; if (inst_addr_ok !== (acc && g == REQ_INST) || data_addr_ok !== (acc && g == REQ_DATA)) begin
                errors++; $display("FAIL rand_addr_ok cyc %0d got inst=%0b data=%0b exp acc=%0b grant=%0b", cyc, inst_addr_ok, data_addr_ok, acc, g);
            end
            checks++; if (inst_data_ok !== (exp_dok && head == REQ_INST) || data_data_ok !== (exp_dok && head == REQ_DATA)) begin
                errors++; $display("FAIL rand_data_ok cyc %0d got inst=%0b data=%0b exp dok=%0b head=%0b", cyc, inst_data_ok, data_data_ok, exp_dok, head);
            end
            if (exp_req) begin
                checks++;
                if (mem_addr !== (g ? data_addr : inst_addr) || mem_wdata !== (g ? data_wdata : inst_wdata) || mem_wr !== (g ? data_wr : inst_wr)) begin
                    errors++; $display("FAIL rand_fields cyc %0d got addr=%h wdata=%h wr=%0b for grant=%0b", cyc, mem_addr, mem_wdata, mem_wr, g);
                end
            end
            if (exp_dok) begin
                checks++; if (inst_rdata !== mem_rdata || data_rdata !== mem_rdata) begin errors++; $display("FAIL rand_rdata cyc %0d got %h/%h exp %h", cyc, inst_rdata, data_rdata, mem_rdata); end
                void'(q.pop_front());
            end
            if (acc) begin
                q.push_back(g);
                rr_pref = ~g;
                lock_v = 0;
            end else if (exp_req) begin
                lock_v = 1; lock_id = g;
            end
            clr_inst = acc && (g == REQ_INST);
            clr_data = acc && (g == REQ_DATA);
            step();
        end
        inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        for (int i = 0; i < OUTS; i++) step();
        mem_data_ok = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_inst_read();
        test_both();
        test_lock();
        test_full();
        test_reset_mid();
`ifdef SRAM_ARB_RR_EN
        test_rr();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
